// File: rtl/datapath.sv
// Program-counter datapath with two-level prioritised interrupt handling.
// PC counts up each cycle unless overwritten by a host write, an interrupt
// entry (vectoring to 0x0020 / 0x0010) or an interrupt return (restoring EPC).
// Interrupt requests are rising-edge detected into pending bits that remain
// latched until serviced; no nesting is allowed while in service.
module datapath (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        intWrite,
    input  logic [15:0] intDataIn,
    input  logic        int1,
    input  logic        int0,
    input  logic        intLvl1,
    input  logic        intLvl0,
    output logic        intr,
    output logic [15:0] intDataOut
);

    localparam logic [15:0] VEC_INT1 = 16'h0020;
    localparam logic [15:0] VEC_INT0 = 16'h0010;

    logic [15:0] pc;
    logic [15:0] epc;
    logic        p1;
    logic        p0;
    logic        s;
    logic        prev1;
    logic        prev0;

    logic [1:0]  lvl;
    logic        rise1;
    logic        rise0;
    logic        en1;
    logic        en0;
    logic        take1;
    logic        take0;

    // Edge detection, mask evaluation and interrupt-take arbitration.
    always_comb begin
        lvl   = {intLvl1, intLvl0};
        rise1 = int1 & ~prev1;
        rise0 = int0 & ~prev0;
        // A source is enabled only when its priority exceeds the mask level.
        en1   = (lvl <= 2'd1);
        en0   = (lvl == 2'd0);
        // A write (either return or PC load) pre-empts any take; in service blocks nesting.
        take1 = ~intWrite & ~s & p1 & en1;
        take0 = ~intWrite & ~s & p0 & en0 & ~take1;
    end

    // State update: pending latches, PC/EPC/in-service sequencing.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pc    <= '0;
            epc   <= '0;
            p1    <= 1'b0;
            p0    <= 1'b0;
            s     <= 1'b0;
            prev1 <= 1'b0;
            prev0 <= 1'b0;
        end else begin
            prev1 <= int1;
            prev0 <= int0;
            // A fresh rising edge wins over the clear caused by servicing.
            p1    <= rise1 | (p1 & ~take1);
            p0    <= rise0 | (p0 & ~take0);

            if (intWrite) begin
                if (s) begin
                    pc <= epc;
                    s  <= 1'b0;
                end else begin
                    pc <= intDataIn;
                end
            end else if (take1 || take0) begin
                epc <= pc;
                pc  <= take1 ? VEC_INT1 : VEC_INT0;
                s   <= 1'b1;
            end else begin
                pc <= pc + 16'd1;
            end
        end
    end

    assign intr       = s;
    assign intDataOut = pc;

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath: reset behaviour, PC load/wrap,
// interrupt entry/return, priority, masking, set-wins and mid-service reset.
module tb_datapath;

    logic        CLK;
    logic        Reset;
    logic        intWrite;
    logic [15:0] intDataIn;
    logic        int1;
    logic        int0;
    logic        intLvl1;
    logic        intLvl0;
    logic        intr;
    logic [15:0] intDataOut;

    int checks;
    int errors;

    datapath dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .intWrite   (intWrite),
        .intDataIn  (intDataIn),
        .int1       (int1),
        .int0       (int0),
        .intLvl1    (intLvl1),
        .intLvl0    (intLvl0),
        .intr       (intr),
        .intDataOut (intDataOut)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [15:0] pc_exp, input logic s_exp);
        check({tag, ".pc"}, intDataOut, pc_exp);
        check({tag, ".intr"}, {15'd0, intr}, {15'd0, s_exp});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        Reset     = 1'b0;
        intWrite  = 1'b0;
        intDataIn = '0;
        int1      = 1'b0;
        int0      = 1'b0;
        intLvl1   = 1'b0;
        intLvl0   = 1'b0;

        // Reset held across edges.
        tick();
        tick();
        expect_state("rst_hold", 16'h0000, 1'b0);
        Reset = 1'b1;
        tick(); expect_state("rel1", 16'h0001, 1'b0);
        tick(); expect_state("rel2", 16'h0002, 1'b0);

        // PC load and wrap.
        intWrite = 1'b1; intDataIn = 16'hFFFE;
        tick(); expect_state("load_fffe", 16'hFFFE, 1'b0);
        intWrite = 1'b0; intDataIn = 16'h0000;
        tick(); expect_state("cnt_ffff", 16'hFFFF, 1'b0);
        tick(); expect_state("wrap_0000", 16'h0000, 1'b0);

        // Single int0 at L=0 from PC=0040.
        intWrite = 1'b1; intDataIn = 16'h0040;
        tick(); expect_state("load_0040", 16'h0040, 1'b0);
        intWrite = 1'b0;
        int0 = 1'b1;
        tick(); expect_state("i0_pend", 16'h0041, 1'b0);
        tick(); expect_state("i0_take", 16'h0010, 1'b1);
        int0 = 1'b0;
        tick(); expect_state("i0_run1", 16'h0011, 1'b1);
        tick(); expect_state("i0_run2", 16'h0012, 1'b1);
        intWrite = 1'b1;
        tick(); expect_state("i0_ret", 16'h0041, 1'b0);
        intWrite = 1'b0;
        tick(); expect_state("i0_after", 16'h0042, 1'b0);

        // Simultaneous int1/int0: int1 first, int0 after return.
        int1 = 1'b1; int0 = 1'b1;
        tick(); expect_state("both_pend", 16'h0043, 1'b0);
        tick(); expect_state("both_take1", 16'h0020, 1'b1);
        int1 = 1'b0; int0 = 1'b0;
        tick(); expect_state("both_run", 16'h0021, 1'b1);
        intWrite = 1'b1;
        tick(); expect_state("both_ret1", 16'h0043, 1'b0);
        intWrite = 1'b0;
        tick(); expect_state("both_take0", 16'h0010, 1'b1);
        tick(); expect_state("both_run0", 16'h0011, 1'b1);
        intWrite = 1'b1;
        tick(); expect_state("both_ret0", 16'h0043, 1'b0);
        intWrite = 1'b0;
        tick(); expect_state("both_after", 16'h0044, 1'b0);

        // L=1 masks int0; pending retained until L drops to 0.
        intLvl0 = 1'b1;
        int0 = 1'b1;
        tick(); expect_state("m1_pend", 16'h0045, 1'b0);
        tick(); expect_state("m1_hold1", 16'h0046, 1'b0);
        int0 = 1'b0;
        tick(); expect_state("m1_hold2", 16'h0047, 1'b0);
        intLvl0 = 1'b0;
        tick(); expect_state("m1_take", 16'h0010, 1'b1);
        intWrite = 1'b1;
        tick(); expect_state("m1_ret", 16'h0047, 1'b0);
        intWrite = 1'b0;
        tick(); expect_state("m1_after", 16'h0048, 1'b0);

        // L=2 masks int1; return ignores intDataIn.
        intLvl1 = 1'b1;
        int1 = 1'b1;
        tick(); expect_state("m2_pend", 16'h0049, 1'b0);
        int1 = 1'b0;
        tick(); expect_state("m2_hold", 16'h004A, 1'b0);
        intLvl1 = 1'b0; intLvl0 = 1'b1;
        tick(); expect_state("m2_take_l1", 16'h0020, 1'b1);
        intLvl1 = 1'b1; intLvl0 = 1'b0;
        intWrite = 1'b1; intDataIn = 16'h1234;
        tick(); expect_state("m2_ret_ign", 16'h004A, 1'b0);
        intWrite = 1'b0; intDataIn = 16'h0000;
        tick(); expect_state("m2_after", 16'h004B, 1'b0);

        // New int0 edge coinciding with its take keeps P0 set.
        intLvl1 = 1'b0; intLvl0 = 1'b0;
        int1 = 1'b1;
        tick(); expect_state("sw_p1", 16'h004C, 1'b0);
        int1 = 1'b0;
        tick(); expect_state("sw_take1", 16'h0020, 1'b1);
        int0 = 1'b1;
        tick(); expect_state("sw_p0", 16'h0021, 1'b1);
        int0 = 1'b0;
        tick(); expect_state("sw_run", 16'h0022, 1'b1);
        intWrite = 1'b1;
        tick(); expect_state("sw_ret1", 16'h004C, 1'b0);
        intWrite = 1'b0;
        int0 = 1'b1;
        tick(); expect_state("sw_take0", 16'h0010, 1'b1);
        int0 = 1'b0;
        tick(); expect_state("sw_run0", 16'h0011, 1'b1);
        intWrite = 1'b1;
        tick(); expect_state("sw_ret0", 16'h004C, 1'b0);
        intWrite = 1'b0;
        tick(); expect_state("sw_retake", 16'h0010, 1'b1);
        intWrite = 1'b1;
        tick(); expect_state("sw_ret2", 16'h004C, 1'b0);
        intWrite = 1'b0;
        tick(); expect_state("sw_after", 16'h004D, 1'b0);

        // Asynchronous reset mid-service with int0 pending.
        int1 = 1'b1;
        tick(); expect_state("mr_p1", 16'h004E, 1'b0);
        int1 = 1'b0;
        tick(); expect_state("mr_take", 16'h0020, 1'b1);
        int0 = 1'b1;
        tick(); expect_state("mr_p0", 16'h0021, 1'b1);
        #2;
        Reset = 1'b0;
        #1;
        expect_state("mr_async", 16'h0000, 1'b0);
        tick(); expect_state("mr_hold", 16'h0000, 1'b0);
        int0 = 1'b0;
        Reset = 1'b1;
        tick(); expect_state("mr_rel1", 16'h0001, 1'b0);
        tick(); expect_state("mr_rel2", 16'h0002, 1'b0);
        tick(); expect_state("mr_rel3", 16'h0003, 1'b0);
        tick(); expect_state("mr_rel4", 16'h0004, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
